control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; state encodings FETCH=3'b000, DECODE=3'b001, EXECUTE=3'b010, MEMORY=3'b011, WRITEBACK=3'b100, HALT_STATE=3'b101 SHALL be fixed constants.
REQ-002 clk  in  1  sole clock; state register updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 instr  in  8  instruction register contents: opcode=[7:5], reg=[4] (0=A, 1=B), imm=[3:0].
REQ-005 zf  in  1  registered zero flag.
REQ-006 state  out  3  current FSM state (registered).
REQ-007 next_state  out  3  combinational next FSM state.
REQ-008 pc_we / pc_sel / pc_jmp_sel  out  1 each  PC write; 0=PC+1, 1=jump target; 0=absolute target, 1=PC-relative target.
REQ-009 pc_offset  out  4  jump target/offset.
REQ-010 addr_sel / addr_offset  out  1 / 4  1=data address from addr_offset, 0=PC; memory offset.
REQ-011 mem_sel / mem_we  out  1 each  store source (0=A, 1=B); memory write enable.
REQ-012 alu_opcode  out  3; alu_sel_a  out 1 (0=A, 1=B); alu_sel_b  out 1 (0=B, 1=imm zero-extended); alu_we / zf_we  out 1 each.
REQ-013 ir_we  out 1; a_sel / b_sel  out 1 each (0=ALU result, 1=memory data); a_we / b_we  out 1 each; halt  out 1.

Function
REQ-014 Opcodes SHALL be: 000 NOP, 001 ALU-R (op=instr[2:0], A op B -> reg), 010 ADDI (reg + imm -> reg), 011 LOAD reg,[imm], 100 STORE reg,[imm], 101 JMP abs (reg bit 0=always, 1=only if zf), 110 BR rel (same condition), 111 HALT.
REQ-015 Every output not explicitly asserted in a state SHALL be 0, including pc_offset, addr_offset and alu_opcode.
REQ-016 FETCH: ir_we=1, pc_we=1, pc_sel=0; next DECODE.
REQ-017 DECODE: no strobes; next HALT_STATE for opcode 111, else EXECUTE.
REQ-018 EXECUTE, ALU-R: alu_opcode=instr[2:0], alu_sel_a=0, alu_sel_b=0, alu_we=1, zf_we=1; next WRITEBACK.
REQ-019 EXECUTE, ADDI: alu_opcode=000, alu_sel_a=instr[4], alu_sel_b=1, alu_we=1, zf_we=1; next WRITEBACK.
REQ-020 EXECUTE, LOAD/STORE: no strobes; next MEMORY.
REQ-021 EXECUTE, JMP/BR taken (unconditional, or conditional with zf=1): pc_we=1, pc_sel=1, pc_offset=instr[3:0], pc_jmp_sel=0 (JMP) or 1 (BR); not taken: no strobes; next FETCH.
REQ-022 EXECUTE, NOP: next FETCH.
REQ-023 MEMORY, LOAD: addr_sel=1, addr_offset=instr[3:0], mem_we=0, mem_sel=0; next WRITEBACK.
REQ-024 MEMORY, STORE: addr_sel=1, addr_offset=instr[3:0], mem_we=1, mem_sel=instr[4]; next FETCH.
REQ-025 MEMORY with any other opcode: no strobes; next FETCH.
REQ-026 WRITEBACK: LOAD asserts a_we (instr[4]=0) or b_we (instr[4]=1) with matching a_sel/b_sel=1; ALU-R/ADDI asserts the same write enable with sel=0; next FETCH.
REQ-027 HALT_STATE: halt=1, all other strobes 0, next HALT_STATE until reset.
REQ-028 Encodings 3'b110/3'b111: all outputs 0, next FETCH.
REQ-029 Outputs other than state SHALL be purely combinational from state, instr, zf and reset.

Reset
REQ-030 While reset=0: state SHALL be FETCH immediately (asynchronous), next_state=FETCH, all control outputs 0; first FETCH strobes SHALL appear after reset rises.
REQ-031 Reset mid-instruction SHALL abandon the instruction with no further strobes.

Structure
REQ-032 State encodings and opcode constants SHALL reside in a shared cpu package used by datapath and control_unit.
REQ-033 No sub-module; one registered state process plus one combinational decode block.

Verification
REQ-034 State MEMORY, instr=8'b01101111 -> next WRITEBACK, addr_sel=1, addr_offset=4'hF, mem_sel=0, mem_we=0, all others 0.
REQ-035 State MEMORY, instr=8'b10010011 -> next FETCH, addr_sel=1, addr_offset=4'h3, mem_sel=1, mem_we=1, all others 0.
REQ-036 Full cycle for 8'b00110010 (ALU-R, op 010, dest B) -> FETCH/DECODE/EXECUTE(alu_opcode=010, alu_we=1, zf_we=1)/WRITEBACK(b_we=1, b_sel=0)/FETCH.
REQ-037 EXECUTE, instr=8'b10110101 (JZ abs 5): zf=0 -> pc_we=0; zf=1 -> pc_we=1, pc_sel=1, pc_jmp_sel=0, pc_offset=4'h5.
REQ-038 Opcode 111 -> DECODE to HALT_STATE; halt=1 held over 3 clocks; reset low -> state FETCH without a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM state encodings, opcodes and branch helper.
// Used by both the datapath and the control unit.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ALUR  = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_BR    = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'b000;

    // cond=0 jumps always, cond=1 only when the zero flag is set
    function automatic logic branch_taken(input logic cond, input logic zf);
        return !cond || zf;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback/halt.
// Every strobe is decoded combinationally from state, instr, zf and reset.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       zf,
    output logic [2:0] state,
    output logic [2:0] next_state,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       pc_jmp_sel,
    output logic [3:0] pc_offset,
    output logic       addr_sel,
    output logic [3:0] addr_offset,
    output logic       mem_sel,
    output logic       mem_we,
    output logic [2:0] alu_opcode,
    output logic       alu_sel_a,
    output logic       alu_sel_b,
    output logic       alu_we,
    output logic       zf_we,
    output logic       ir_we,
    output logic       a_sel,
    output logic       b_sel,
    output logic       a_we,
    output logic       b_we,
    output logic       halt
);

    state_t     state_q;
    logic [2:0] state_d;
    logic [2:0] op;
    logic       rsel;
    logic [3:0] imm;

    assign op   = instr[7:5];
    assign rsel = instr[4];
    assign imm  = instr[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_t'(state_d);
    end

    assign state      = state_q;
    assign next_state = state_d;

    always_comb begin
        state_d     = FETCH;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        pc_jmp_sel  = 1'b0;
        pc_offset   = 4'h0;
        addr_sel    = 1'b0;
        addr_offset = 4'h0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        alu_opcode  = 3'b000;
        alu_sel_a   = 1'b0;
        alu_sel_b   = 1'b0;
        alu_we      = 1'b0;
        zf_we       = 1'b0;
        ir_we       = 1'b0;
        a_sel       = 1'b0;
        b_sel       = 1'b0;
        a_we        = 1'b0;
        b_we        = 1'b0;
        halt        = 1'b0;

        // reset low forces FETCH and silences every strobe
        if (reset) begin
            case (state_q)
                FETCH: begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end
                DECODE: begin
                    state_d = (op == OP_HALT) ? HALT_STATE : EXECUTE;
                end
                EXECUTE: begin
                    case (op)
                        OP_ALUR: begin
                            alu_opcode = instr[2:0];
                            alu_we     = 1'b1;
                            zf_we      = 1'b1;
                            state_d    = WRITEBACK;
                        end
                        OP_ADDI: begin
                            alu_opcode = ALU_ADD;
                            alu_sel_a  = rsel;
                            alu_sel_b  = 1'b1;
                            alu_we     = 1'b1;
                            zf_we      = 1'b1;
                            state_d    = WRITEBACK;
                        end
                        OP_LOAD, OP_STORE: begin
                            state_d = MEMORY;
                        end
                        OP_JMP, OP_BR: begin
                            if (branch_taken(rsel, zf)) begin
                                pc_we      = 1'b1;
                                pc_sel     = 1'b1;
                                pc_offset  = imm;
                                pc_jmp_sel = (op == OP_BR);
                            end
                            state_d = FETCH;
                        end
                        default: state_d = FETCH;
                    endcase
                end
                MEMORY: begin
                    if (op == OP_LOAD) begin
                        addr_sel    = 1'b1;
                        addr_offset = imm;
                        state_d     = WRITEBACK;
                    end else if (op == OP_STORE) begin
                        addr_sel    = 1'b1;
                        addr_offset = imm;
                        mem_sel     = rsel;
                        mem_we      = 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (op == OP_LOAD || op == OP_ALUR || op == OP_ADDI) begin
                        a_we  = !rsel;
                        b_we  = rsel;
                        a_sel = !rsel && (op == OP_LOAD);
                        b_sel = rsel && (op == OP_LOAD);
                    end
                end
                HALT_STATE: begin
                    halt    = 1'b1;
                    state_d = HALT_STATE;
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected outputs are queued
// when an instruction is applied and popped as the FSM steps through it.
module tb_control_unit;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] nx;
        logic       pc_we;
        logic       pc_sel;
        logic       pc_jmp_sel;
        logic [3:0] pc_offset;
        logic       addr_sel;
        logic [3:0] addr_offset;
        logic       mem_sel;
        logic       mem_we;
        logic [2:0] alu_opcode;
        logic       alu_sel_a;
        logic       alu_sel_b;
        logic       alu_we;
        logic       zf_we;
        logic       ir_we;
        logic       a_sel;
        logic       b_sel;
        logic       a_we;
        logic       b_we;
        logic       halt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic       zf;
    logic [2:0] state, next_state;
    logic       pc_we, pc_sel, pc_jmp_sel;
    logic [3:0] pc_offset;
    logic       addr_sel;
    logic [3:0] addr_offset;
    logic       mem_sel, mem_we;
    logic [2:0] alu_opcode;
    logic       alu_sel_a, alu_sel_b, alu_we, zf_we;
    logic       ir_we, a_sel, b_sel, a_we, b_we, halt;

    int   n_cmp = 0;
    int   n_err = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .instr(instr), .zf(zf),
        .state(state), .next_state(next_state),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_jmp_sel(pc_jmp_sel),
        .pc_offset(pc_offset), .addr_sel(addr_sel),
        .addr_offset(addr_offset), .mem_sel(mem_sel), .mem_we(mem_we),
        .alu_opcode(alu_opcode), .alu_sel_a(alu_sel_a),
        .alu_sel_b(alu_sel_b), .alu_we(alu_we), .zf_we(zf_we),
        .ir_we(ir_we), .a_sel(a_sel), .b_sel(b_sel),
        .a_we(a_we), .b_we(b_we), .halt(halt)
    );

    function automatic obs_t sample();
        obs_t o;
        o = '{state, next_state, pc_we, pc_sel, pc_jmp_sel, pc_offset,
              addr_sel, addr_offset, mem_sel, mem_we, alu_opcode,
              alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we,
              a_sel, b_sel, a_we, b_we, halt};
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %09h want %09h (state %0d/%0d)",
                     tag, got, exp, got.st, exp.st);
        end
    endtask

    // expected per-cycle outputs for one instruction starting in FETCH
    task automatic push_instr(input logic [7:0] i, input logic z);
        obs_t       e;
        logic [2:0] op;
        logic       r;
        op = i[7:5];
        r  = i[4];
        e = '0; e.st = 3'd0; e.nx = 3'd1; e.ir_we = 1; e.pc_we = 1;
        exp_q.push_back(e);
        e = '0; e.st = 3'd1; e.nx = (op == 3'd7) ? 3'd5 : 3'd2;
        exp_q.push_back(e);
        if (op == 3'd7) begin
            e = '0; e.st = 3'd5; e.nx = 3'd5; e.halt = 1;
            repeat (3) exp_q.push_back(e);
            return;
        end
        e = '0; e.st = 3'd2; e.nx = 3'd0;
        if (op == 3'd1) begin
            e.alu_opcode = i[2:0]; e.alu_we = 1; e.zf_we = 1; e.nx = 3'd4;
        end else if (op == 3'd2) begin
            e.alu_sel_a = r; e.alu_sel_b = 1;
            e.alu_we = 1; e.zf_we = 1; e.nx = 3'd4;
        end else if (op == 3'd3 || op == 3'd4) begin
            e.nx = 3'd3;
        end else if ((op == 3'd5 || op == 3'd6) && (!r || z)) begin
            e.pc_we = 1; e.pc_sel = 1; e.pc_offset = i[3:0];
            e.pc_jmp_sel = (op == 3'd6);
        end
        exp_q.push_back(e);
        if (op == 3'd3 || op == 3'd4) begin
            e = '0; e.st = 3'd3; e.addr_sel = 1; e.addr_offset = i[3:0];
            if (op == 3'd3) e.nx = 3'd4;
            else begin e.nx = 3'd0; e.mem_we = 1; e.mem_sel = r; end
            exp_q.push_back(e);
        end
        if (op == 3'd1 || op == 3'd2 || op == 3'd3) begin
            e = '0; e.st = 3'd4; e.nx = 3'd0;
            e.a_we = !r; e.b_we = r;
            e.a_sel = !r && (op == 3'd3);
            e.b_sel = r && (op == 3'd3);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string nm, input int max_cycles);
        int c = 0;
        while (exp_q.size() > 0 && c < max_cycles) begin
            check($sformatf("%s_c%0d", nm, c), sample(), exp_q.pop_front());
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic run(input logic [7:0] i, input logic z, input string nm);
        instr = i;
        zf    = z;
        push_instr(i, z);
        drain(nm, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        instr = 8'hFF;
        zf    = 1'b1;
        #13;
        check("rst_hold", sample(), '0);
        @(negedge clk); reset = 1'b1; #1;

        run(8'b00110010, 1'b0, "alur_b");
        run(8'b00100101, 1'b1, "alur_a");
        run(8'b01011001, 1'b0, "addi_b");
        run(8'b01000111, 1'b0, "addi_a");
        run(8'b01101111, 1'b0, "load_b");
        run(8'b01100100, 1'b1, "load_a");
        run(8'b10010011, 1'b0, "store_b");
        run(8'b10001010, 1'b1, "store_a");
        run(8'b10110101, 1'b0, "jz_nt");
        run(8'b10110101, 1'b1, "jz_t");
        run(8'b10101100, 1'b0, "jmp");
        run(8'b11010110, 1'b0, "bz_nt");
        run(8'b11010110, 1'b1, "bz_t");
        run(8'b11001001, 1'b0, "br");
        run(8'b00011111, 1'b1, "nop");

        // reset while a LOAD sits in MEMORY
        instr = 8'b01110001;
        zf    = 1'b0;
        push_instr(instr, zf);
        drain("mid", 3);
        reset = 1'b0; #1;
        check("mid_rst_async", sample(), '0);
        exp_q.delete();
        @(posedge clk); #1;
        check("mid_rst_edge", sample(), '0);
        @(negedge clk); reset = 1'b1; #1;

        run(8'b01110001, 1'b0, "load_after");
        run(8'b11100000, 1'b0, "halt");
        reset = 1'b0; #1;
        check("halt_rst_async", sample(), '0);
        @(negedge clk); reset = 1'b1; #1;
        run(8'b00111011, 1'b0, "alur_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
